// File: rtl/pipe_pkg.sv
// Shared types and constants for the EX/MEM pipeline stage.
//   stage_state_e    : occupancy of a valid/ready stage (empty, main only, main + skid)
//   WB_SEL_*         : writeback source select encodings
//   ex_mem_payload_t : default-width (XLEN=32, REG_AW=5) payload layout, MSB first
//   payload_width()  : packed payload width for any XLEN/REG_AW
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } stage_state_e;

    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;

    localparam int unsigned XLEN_DEF   = 32;
    localparam int unsigned REG_AW_DEF = 5;

    typedef struct packed {
        logic [XLEN_DEF-1:0]   pc_plus_4;
        logic [XLEN_DEF-1:0]   rs2_data;
        logic [XLEN_DEF-1:0]   alu_result;
        logic [REG_AW_DEF-1:0] rd;
        logic [1:0]            wr_data_sel;
        logic                  reg_wr;
        logic                  mem_rd;
        logic                  mem_wr;
    } ex_mem_payload_t;

    // Three XLEN fields, rd, 2-bit select and three strobes.
    function automatic int unsigned payload_width(int unsigned xlen, int unsigned reg_aw);
        return 3 * xlen + reg_aw + 5;
    endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX/MEM stage bus: upstream (in_*) payload with valid/ready and downstream (out_*) payload
// with valid/ready.
//   master : the environment (execute stage drives in_*, memory stage drives out_ready)
//   slave  : the pipeline stage itself
interface ex_mem_stage_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_pc_plus_4;
    logic [XLEN-1:0]   in_rs2_data;
    logic [XLEN-1:0]   in_alu_result;
    logic [REG_AW-1:0] in_rd;
    logic [1:0]        in_wr_data_sel;
    logic              in_reg_wr;
    logic              in_mem_rd;
    logic              in_mem_wr;

    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc_plus_4;
    logic [XLEN-1:0]   out_rs2_data;
    logic [XLEN-1:0]   out_alu_result;
    logic [REG_AW-1:0] out_rd;
    logic [1:0]        out_wr_data_sel;
    logic              out_reg_wr;
    logic              out_mem_rd;
    logic              out_mem_wr;

    modport master (
        output in_valid, in_pc_plus_4, in_rs2_data, in_alu_result, in_rd, in_wr_data_sel,
               in_reg_wr, in_mem_rd, in_mem_wr, out_ready,
        input  in_ready, out_valid, out_pc_plus_4, out_rs2_data, out_alu_result, out_rd,
               out_wr_data_sel, out_reg_wr, out_mem_rd, out_mem_wr
    );

    modport slave (
        input  in_valid, in_pc_plus_4, in_rs2_data, in_alu_result, in_rd, in_wr_data_sel,
               in_reg_wr, in_mem_rd, in_mem_wr, out_ready,
        output in_ready, out_valid, out_pc_plus_4, out_rs2_data, out_alu_result, out_rd,
               out_wr_data_sel, out_reg_wr, out_mem_rd, out_mem_wr
    );
endinterface

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready pipeline stage holding a W-bit main entry and, when SKID=1, a second
// skid entry so that in_ready can come straight from a register.
//   clk, reset            : clock, synchronous active-high reset
//   flush                 : drop all held entries and any entry arriving this cycle
//   in_valid/in_ready     : upstream handshake, in_data payload
//   out_valid/out_ready   : downstream handshake, out_data payload (always main entry)
// All outputs read 0 while reset is high.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int unsigned W    = 32,
    parameter bit          SKID = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    localparam logic [1:0] S_EMPTY = ST_EMPTY;
    localparam logic [1:0] S_FULL  = ST_FULL;
    localparam logic [1:0] S_SKID  = ST_SKID;

    logic [1:0]   state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         in_fire, out_fire;

    // SKID=1: in_ready depends only on the state register. SKID=0: pass-through of out_ready,
    // which keeps the skid state unreachable.
    if (SKID) begin : g_skid
        assign in_ready = !reset && (state_q != S_SKID);
    end else begin : g_noskid
        assign in_ready = !reset && (out_ready || (state_q == S_EMPTY));
    end

    assign out_valid = !reset && (state_q != S_EMPTY);
    assign out_data  = reset ? '0 : main_q;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            S_EMPTY: begin
                if (in_fire) begin
                    state_d = S_FULL;
                    main_d  = in_data;
                end
            end
            S_FULL: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire) begin
                    state_d = S_SKID;
                    skid_d  = in_data;
                end else if (out_fire) begin
                    state_d = S_EMPTY;
                end
            end
            S_SKID: begin
                if (out_fire) begin
                    state_d = S_FULL;
                    main_d  = skid_q;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        // Payload may still be captured; it is stale once the stage reads empty.
        if (flush) begin
            state_d = S_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: carries PC+4, rs2 data, ALU result, rd and control bits from execute
// to memory with valid/ready flow control, flush and a saturating stall-cycle counter.
//   clk, reset : clock, synchronous active-high reset (all outputs 0 while high)
//   flush      : kill held entries and the entry arriving this cycle
//   bus        : ex_mem_stage_if slave (in_* / out_* payload and handshakes)
//   stall_cnt  : cycles with out_valid & !out_ready (flush cycles excluded), saturating
module ex_mem_stage
    import pipe_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5,
    parameter bit          SKID   = 1'b1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    ex_mem_stage_if.slave    bus,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned W = payload_width(XLEN, REG_AW);

    // Same field order as ex_mem_payload_t, sized by this instance's parameters.
    typedef struct packed {
        logic [XLEN-1:0]   pc_plus_4;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   alu_result;
        logic [REG_AW-1:0] rd;
        logic [1:0]        wr_data_sel;
        logic              reg_wr;
        logic              mem_rd;
        logic              mem_wr;
    } payload_t;

    payload_t         in_pl, out_pl;
    logic             out_valid;
    logic [CNT_W-1:0] cnt_q;

    assign in_pl = '{
        pc_plus_4:   bus.in_pc_plus_4,
        rs2_data:    bus.in_rs2_data,
        alu_result:  bus.in_alu_result,
        rd:          bus.in_rd,
        wr_data_sel: bus.in_wr_data_sel,
        reg_wr:      bus.in_reg_wr,
        mem_rd:      bus.in_mem_rd,
        mem_wr:      bus.in_mem_wr
    };

    pipe_skid_buf #(
        .W    (W),
        .SKID (SKID)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (in_pl),
        .out_valid (out_valid),
        .out_ready (bus.out_ready),
        .out_data  (out_pl)
    );

    assign bus.out_valid       = out_valid;
    assign bus.out_pc_plus_4   = out_pl.pc_plus_4;
    assign bus.out_rs2_data    = out_pl.rs2_data;
    assign bus.out_alu_result  = out_pl.alu_result;
    assign bus.out_rd          = out_pl.rd;
    assign bus.out_wr_data_sel = out_pl.wr_data_sel;
    // Bubbles must never write, whatever stale payload the register holds.
    assign bus.out_reg_wr      = out_pl.reg_wr && out_valid;
    assign bus.out_mem_rd      = out_pl.mem_rd && out_valid;
    assign bus.out_mem_wr      = out_pl.mem_wr && out_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (out_valid && !bus.out_ready && !flush && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign stall_cnt = reset ? '0 : cnt_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: a SKID=1 and a SKID=0 build (both CNT_W=4) share one stimulus stream.
// Each build has a FIFO scoreboard: accepted entries are queued at the clock edge, a negedge
// monitor checks every output against the queue head and the occupancy-derived handshakes.
module tb_ex_mem_stage;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned W      = 3 * XLEN + REG_AW + 5;
    localparam int          CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset, flush, in_valid, out_ready;
    logic [XLEN-1:0]   pc4, rs2, alu;
    logic [REG_AW-1:0] rd;
    logic [1:0]        sel;
    logic              rw, mr, mw;
    logic [CNT_W-1:0]  stall0, stall1;
    logic [W-1:0]      in_word;

    logic [W-1:0] sb [2][$];
    int           exp_cnt [2];
    int           n_total = 0;
    int           n_bad   = 0;

    always #5 clk = ~clk;

    assign in_word = {pc4, rs2, alu, rd, sel, rw, mr, mw};

    ex_mem_stage_if #(.XLEN(XLEN), .REG_AW(REG_AW)) bus0 ();
    ex_mem_stage_if #(.XLEN(XLEN), .REG_AW(REG_AW)) bus1 ();

    assign bus0.in_valid = in_valid;       assign bus1.in_valid = in_valid;
    assign bus0.in_pc_plus_4 = pc4;        assign bus1.in_pc_plus_4 = pc4;
    assign bus0.in_rs2_data = rs2;         assign bus1.in_rs2_data = rs2;
    assign bus0.in_alu_result = alu;       assign bus1.in_alu_result = alu;
    assign bus0.in_rd = rd;                assign bus1.in_rd = rd;
    assign bus0.in_wr_data_sel = sel;      assign bus1.in_wr_data_sel = sel;
    assign bus0.in_reg_wr = rw;            assign bus1.in_reg_wr = rw;
    assign bus0.in_mem_rd = mr;            assign bus1.in_mem_rd = mr;
    assign bus0.in_mem_wr = mw;            assign bus1.in_mem_wr = mw;
    assign bus0.out_ready = out_ready;     assign bus1.out_ready = out_ready;

    ex_mem_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .SKID(1'b1), .CNT_W(CNT_W)) u_dut0 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .bus       (bus0),
        .stall_cnt (stall0)
    );

    ex_mem_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .SKID(1'b0), .CNT_W(CNT_W)) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .bus       (bus1),
        .stall_cnt (stall1)
    );

    // Capacity 2 with a registered ready (build 0), capacity 1 with pass-through ready (build 1).
    function automatic logic model_ready(int i);
        if (i == 0) return sb[0].size() < 2;
        return (sb[1].size() == 0) || out_ready;
    endfunction

    task automatic chk(string name, int i, logic [127:0] got, logic [127:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s dut%0d at %0t: got %h want %h", name, i, $time, got, want);
        end
    endtask

    // Reference model: one FIFO per build, updated on each clock edge from bench-driven inputs.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic rdy;
            rdy = model_ready(i);
            if (reset) begin
                sb[i].delete();
                exp_cnt[i] = 0;
            end else if (flush) begin
                sb[i].delete();
            end else begin
                if (sb[i].size() > 0 && !out_ready && exp_cnt[i] < CMAX) exp_cnt[i]++;
                if (sb[i].size() > 0 && out_ready) void'(sb[i].pop_front());
                if (in_valid && rdy) sb[i].push_back(in_word);
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [W-1:0]     act;
            logic             a_valid, a_ready;
            logic [CNT_W-1:0] a_cnt;
            if (i == 0) begin
                act = {bus0.out_pc_plus_4, bus0.out_rs2_data, bus0.out_alu_result, bus0.out_rd,
                       bus0.out_wr_data_sel, bus0.out_reg_wr, bus0.out_mem_rd, bus0.out_mem_wr};
                a_valid = bus0.out_valid;
                a_ready = bus0.in_ready;
                a_cnt   = stall0;
            end else begin
                act = {bus1.out_pc_plus_4, bus1.out_rs2_data, bus1.out_alu_result, bus1.out_rd,
                       bus1.out_wr_data_sel, bus1.out_reg_wr, bus1.out_mem_rd, bus1.out_mem_wr};
                a_valid = bus1.out_valid;
                a_ready = bus1.in_ready;
                a_cnt   = stall1;
            end
            if (reset) begin
                chk("reset_out_valid", i, 128'(a_valid), 128'(0));
                chk("reset_in_ready", i, 128'(a_ready), 128'(0));
                chk("reset_stall_cnt", i, 128'(a_cnt), 128'(0));
                chk("reset_payload", i, 128'(act), 128'(0));
            end else begin
                chk("out_valid", i, 128'(a_valid), 128'(sb[i].size() > 0));
                chk("in_ready", i, 128'(a_ready), 128'(model_ready(i)));
                chk("stall_cnt", i, 128'(a_cnt), 128'(exp_cnt[i]));
                if (sb[i].size() > 0) begin
                    chk("payload", i, 128'(act), 128'(sb[i][0]));
                end else begin
                    chk("bubble_strobes", i, 128'(act[2:0]), 128'(0));
                end
            end
        end
    end

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rand_payload();
        pc4 = $urandom;
        rs2 = $urandom;
        alu = $urandom;
        rd  = REG_AW'($urandom);
        sel = 2'($urandom_range(0, 2));
        rw  = 1'($urandom);
        mr  = 1'($urandom);
        mw  = 1'($urandom);
    endtask

    initial begin
        logic [XLEN-1:0] stream [3];
        stream = '{32'h10, 32'h20, 32'h30};
        reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        rand_payload();
        rw = 1'b1; mw = 1'b1;
        step(2);
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();

        // Streaming back-to-back
        for (int k = 0; k < 3; k++) begin
            rand_payload();
            alu = stream[k];
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        step(3);

        // Backpressure into the skid entry, then drain
        out_ready = 1'b0; in_valid = 1'b1;
        rand_payload(); alu = 32'hA0; step();
        rand_payload(); alu = 32'hB0; step();
        in_valid = 1'b0;
        step(2);
        out_ready = 1'b1;
        step(3);

        // Flush while holding two entries, with a new entry and out_ready in the same cycle
        out_ready = 1'b0; in_valid = 1'b1;
        rand_payload(); alu = 32'hC0; step();
        rand_payload(); alu = 32'hD0; step();
        rand_payload(); alu = 32'hE0; out_ready = 1'b1; flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0;
        step(2);

        // Bubble with write strobes raised
        in_valid = 1'b0; rw = 1'b1; mw = 1'b1; mr = 1'b1;
        step(2);

        // Stall-counter saturation
        in_valid = 1'b1; out_ready = 1'b0; rand_payload();
        step(20);
        in_valid = 1'b0;
        step(3);
        out_ready = 1'b1;
        step(3);

        // Random traffic with occasional flush and reset
        for (int k = 0; k < 600; k++) begin
            rand_payload();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            reset     = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step(4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
